ex_muldiv_sequencer: RTL and testbench
======================================

Name: ex_muldiv_sequencer

Overview:
- Multi-cycle sequencer for RV32M multiply/divide ops issued from the execute stage.
- Accepts one M-extension op, holds the pipeline with a stall, and iterates a shift-add multiplier or restoring divider one bit per cycle.
- Returns a single-cycle result pulse tagged with rd.
- Sits beside the execute-stage ALU; the EX/MEM mux selects result_data when result_valid is high.

Parameters:
- XLEN, 32: operand and result width.
- RD_W, 5: destination-register tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-high reset (asserted = 1, despite the _n suffix).
- req_valid  in  1  EX holds an M-extension op.
- req_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_rd  in  RD_W  destination tag of the op.
- operand_a  in  XLEN  post-forwarding rs1 value.
- operand_b  in  XLEN  post-forwarding rs2 value.
- flush  in  1  kill the in-flight op.
- stall_out  out  1  freeze IF/ID/EX registers.
- busy  out  1  FSM not in IDLE.
- result_valid  out  1  one-cycle result pulse.
- result_data  out  XLEN  result value.
- result_rd  out  RD_W  tag for result_data.

Behaviour:
- FSM states: IDLE, CALC, DONE. Counter cnt is log2(XLEN) bits wide. Working registers: 2*XLEN accumulator/remainder, XLEN multiplicand/divisor, sign flags, op, rd.
- Reset values: state=IDLE; cnt=0; result_valid=0; result_data=0; result_rd=0; busy=0; stall_out=0.
- stall_out = (IDLE & req_valid & !flush) | (CALC & !flush). It is combinational and forced to 0 while reset_n is high.
- IDLE, req_valid & !flush:
  - Latch op and rd.
  - Latch |a| and |b| per signedness: MULH, DIV and REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; the U variants treat both as unsigned.
  - Latch the negate flags. Clear the accumulator, set cnt=0, go to CALC.
- CALC: one iteration per cycle.
  - Multiply: if multiplier LSB is set, add the multiplicand into the upper accumulator half, then shift right.
  - Divide: shift the remainder left, subtract the divisor, restore if negative, shift in the quotient bit.
  - At cnt==XLEN-1, go to DONE. Otherwise increment cnt.
- DONE:
  - result_valid=1 for exactly this cycle, with result_data/result_rd registered on entry to DONE.
  - Go to IDLE. req_valid is ignored in DONE, so the still-held EX op is not relaunched.
- Latency:
  - Accept cycle, then XLEN CALC cycles, then DONE.
  - result_valid appears in cycle XLEN+2, counting the accept cycle as 1.
  - stall_out is high for XLEN+1 cycles.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - The product is two's-complement negated when the operand signs differ (signed variants only).
- Quotient and remainder signs:
  - Quotient is negated when the signed operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero (special-cased, overrides sign fixup):
  - Quotient = all ones.
  - Remainder = operand_a.
- Signed overflow (0x80000000 / -1):
  - Quotient = 0x80000000.
  - Remainder = 0.
- flush has priority in every state:
  - In IDLE: no accept.
  - In CALC: next state IDLE, no result.
  - In DONE: result_valid forced 0.
- Reset asserted mid-operation: next cycle IDLE with all outputs at reset values.
- Back-to-back ops: a new request is accepted in the IDLE cycle after DONE.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Enabled, divide with operand_b==0 or multiply with either operand ==0: IDLE goes directly to DONE with the architectural result. result_valid is in cycle 2 and stall_out is high for 1 cycle.
- Disabled: every op takes the full XLEN iterations, and zero-operand results come from the normal path plus the divide-by-zero override.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), rd=5 -> result_data=0xFFFFFFEB, result_rd=5, result_valid in cycle 34 only, stall_out high cycles 1-33.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 0xFFFFFFFB/0 -> 0xFFFFFFFB; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- flush at cnt=10 -> no result_valid, stall_out=0 the same cycle, busy=0 next cycle; the following DIVU 9/3 completes with 3. Same check with reset_n pulsed at cnt=10.
- Two back-to-back MULs with rd 5 then 6, req_valid held through DONE -> exactly two result_valid pulses, tags 5 then 6. With MULDIV_EARLY_OUT_EN: DIVU 9/0 -> 0xFFFFFFFF in cycle 2, stall_out high 1 cycle.

Source files
------------

// File: rtl/ex_muldiv_sequencer_if.sv
// rtl/ex_muldiv_sequencer_if.sv - request/result bundle between EX stage and the M-extension sequencer
//
// master: execute stage (drives req_*, operands, flush; observes stall/busy/result)
// slave : ex_muldiv_sequencer
//   req_valid/req_op/req_rd/operand_a/operand_b : M-extension op held in EX
//   flush                                       : kill the in-flight op
//   stall_out/busy                              : pipeline freeze / FSM not idle
//   result_valid/result_data/result_rd          : one-cycle tagged result pulse
interface ex_muldiv_sequencer_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            req_valid;
    logic [2:0]      req_op;
    logic [RD_W-1:0] req_rd;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            stall_out;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result_data;
    logic [RD_W-1:0] result_rd;

    modport master (
        output req_valid, req_op, req_rd, operand_a, operand_b, flush,
        input  stall_out, busy, result_valid, result_data, result_rd
    );

    modport slave (
        input  req_valid, req_op, req_rd, operand_a, operand_b, flush,
        output stall_out, busy, result_valid, result_data, result_rd
    );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// rtl/ex_muldiv_sequencer.sv - bit-serial RV32M multiply/divide sequencer for the execute stage
//
// Ports:
//   clk     : clock, all state updates on the rising edge
//   reset_n : synchronous reset, ACTIVE-HIGH despite the name
//   bus     : ex_muldiv_sequencer_if.slave (request, flush, stall/busy, tagged result)
// Optional feature: define MULDIV_EARLY_OUT_EN to finish zero-operand multiplies and
// divide-by-zero straight from IDLE (result in the cycle after accept).
module ex_muldiv_sequencer #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    ex_muldiv_sequencer_if.slave   bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    // Multiply: {partial product high, multiplier low}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;       // multiplicand or divisor magnitude
    logic              neg_q;       // negate product / quotient
    logic              neg_rem_q;   // remainder takes dividend sign
    logic              divz_q;      // divisor was zero
    logic [2:0]        op_q;
    logic [RD_W-1:0]   rd_q;
    logic              valid_q;
    logic [XLEN-1:0]   data_q;
    logic [RD_W-1:0]   rdo_q;

    // Request decode
    logic            req_is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            accept;

    assign req_is_div = bus.req_op[2];
    assign a_signed   = (bus.req_op == OP_MULH) || (bus.req_op == OP_MULHSU) ||
                        (bus.req_op == OP_DIV)  || (bus.req_op == OP_REM);
    assign b_signed   = (bus.req_op == OP_MULH) || (bus.req_op == OP_DIV) ||
                        (bus.req_op == OP_REM);
    assign a_neg      = a_signed & bus.operand_a[XLEN-1];
    assign b_neg      = b_signed & bus.operand_b[XLEN-1];
    assign a_abs      = a_neg ? (-bus.operand_a) : bus.operand_a;
    assign b_abs      = b_neg ? (-bus.operand_b) : bus.operand_b;
    assign accept     = (state_q == S_IDLE) & bus.req_valid & ~bus.flush;

`ifdef MULDIV_EARLY_OUT_EN
    logic            early;
    logic [XLEN-1:0] early_res;
    assign early     = req_is_div ? (bus.operand_b == '0)
                                  : ((bus.operand_a == '0) || (bus.operand_b == '0));
    // Zero multiply gives 0; divide by zero gives all-ones quotient or the raw dividend.
    assign early_res = !req_is_div   ? '0 :
                       bus.req_op[1] ? bus.operand_a : '1;
`endif

    // One iteration of the datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] mul_nxt;
    logic [2*XLEN-1:0] div_nxt;
    logic [2*XLEN-1:0] acc_nxt;

    assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q})
                               : {1'b0, acc_q[2*XLEN-1:XLEN]};
    assign mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    // Shifted remainder needs XLEN+1 bits; one extra bit on top catches the borrow.
    assign div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opb_q};
    assign div_nxt  = div_diff[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign acc_nxt  = op_q[2] ? div_nxt : mul_nxt;

    // Final result from the last iteration, registered on entry to DONE
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod      = neg_q ? (-acc_nxt) : acc_nxt;
        quot      = acc_nxt[XLEN-1:0];
        rem       = acc_nxt[2*XLEN-1:XLEN];
        final_res = '0;
        case (op_q)
            OP_MUL:                       final_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = divz_q ? '1 : (neg_q ? (-quot) : quot);
            OP_REM, OP_REMU:              final_res = neg_rem_q ? (-rem) : rem;
            default:                      final_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            op_q      <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            rdo_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q      <= bus.req_op;
                        rd_q      <= bus.req_rd;
                        cnt_q     <= '0;
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        divz_q    <= req_is_div & (bus.operand_b == '0);
                        opb_q     <= req_is_div ? b_abs : a_abs;
                        acc_q     <= {{XLEN{1'b0}}, (req_is_div ? a_abs : b_abs)};
`ifdef MULDIV_EARLY_OUT_EN
                        if (early) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b1;
                            data_q  <= early_res;
                            rdo_q   <= bus.req_rd;
                        end else begin
                            state_q <= S_CALC;
                        end
`else
                        state_q <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_nxt;
                        if (cnt_q == CW'(XLEN - 1)) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b1;
                            data_q  <= final_res;
                            rdo_q   <= rd_q;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                // The EX op is still held here; it must not be relaunched.
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.stall_out    = ~reset_n & (accept | ((state_q == S_CALC) & ~bus.flush));
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result_valid = valid_q & ~bus.flush & ~reset_n;
    assign bus.result_data  = data_q;
    assign bus.result_rd    = rdo_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb/tb_ex_muldiv_sequencer.sv - scoreboard bench for ex_muldiv_sequencer
module tb_ex_muldiv_sequencer;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    ex_muldiv_sequencer_if #(.XLEN(32), .RD_W(5)) bus ();

    ex_muldiv_sequencer #(.XLEN(32), .RD_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb_, ua, ub, p;
        logic [31:0] r;
        sa  = {{32{a[31]}}, a};
        sb_ = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        r   = '0;
        case (op)
            3'd0: begin p = sa * sb_; r = p[31:0];  end
            3'd1: begin p = sa * sb_; r = p[63:32]; end
            3'd2: begin p = sa * ub;  r = p[63:32]; end
            3'd3: begin p = ua * ub;  r = p[63:32]; end
            3'd4: if (b == 0) r = 32'hFFFFFFFF;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                  else r = $signed(a) / $signed(b);
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                  else r = $signed(a) % $signed(b);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (op[2] ? (b == 0) : (a == 0 || b == 0)) return 2;
`endif
        return 34;
    endfunction

    // Issue one op for a single cycle, then wait for its result pulse.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp);
        exp_t e;
        exp_t got;
        int   cyc;
        int   stalls;
        int   lat;
        bit   seen;
        e.rd = rd;
        e.data = exp;
        sb.push_back(e);
        lat = exp_lat(op, a, b);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_rd = rd;
        bus.operand_a = a; bus.operand_b = b;
        cyc = 1; stalls = 0; seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.stall_out) stalls++;
            if (bus.result_valid) begin seen = 1'b1; break; end
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            cyc++;
        end
        check({tag, " seen"}, 32'(seen), 32'd1);
        if (seen) begin
            if (sb.size() == 0) begin
                check({tag, " sb_empty"}, 32'd1, 32'd0);
            end else begin
                got = sb.pop_front();
                check({tag, " data"}, bus.result_data, got.data);
                check({tag, " rd"}, 32'(bus.result_rd), 32'(got.rd));
            end
            check({tag, " latency"}, 32'(cyc), 32'(lat));
            check({tag, " stall_cycles"}, 32'(stalls), 32'(lat - 1));
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            @(negedge clk);
            check({tag, " single_pulse"}, 32'(bus.result_valid), 32'd0);
        end else begin
            void'(sb.pop_front());
            bus.req_valid = 1'b0;
        end
    endtask

    // Start an op and abort it at cnt==10 with flush or reset.
    task automatic abort_op(input string tag, input bit use_reset);
        int pulses;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = 3'd5; bus.req_rd = 5'd9;
        bus.operand_a = 32'd100; bus.operand_b = 32'd7;
        @(posedge clk); #1;           // cnt==0
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;                            // cnt==10
        if (use_reset) reset_n = 1'b1; else bus.flush = 1'b1;
        @(negedge clk);
        check({tag, " stall_same_cycle"}, 32'(bus.stall_out), 32'd0);
        check({tag, " no_valid_same_cycle"}, 32'(bus.result_valid), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        check({tag, " busy_next"}, 32'(bus.busy), 32'd0);
        if (use_reset) begin
            check({tag, " data_reset"}, bus.result_data, 32'd0);
            check({tag, " rd_reset"}, 32'(bus.result_rd), 32'd0);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        check({tag, " no_result"}, 32'(pulses), 32'd0);
        run_op({tag, " DIVU 9/3"}, 3'd5, 32'd9, 32'd3, 5'd4, 32'd3);
    endtask

    task automatic back_to_back();
        exp_t e;
        exp_t got;
        int   pulses;
        bit   switched;
        e.rd = 5'd5; e.data = 32'd12; sb.push_back(e);
        e.rd = 5'd6; e.data = 32'd30; sb.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_rd = 5'd5;
        bus.operand_a = 32'd3; bus.operand_b = 32'd4;
        pulses = 0; switched = 1'b0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                pulses++;
                if (sb.size() == 0) begin
                    check("b2b sb_empty", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    check("b2b data", bus.result_data, got.data);
                    check("b2b rd", 32'(bus.result_rd), 32'(got.rd));
                end
            end
            @(posedge clk); #1;
            // EX advances to the next op only in the IDLE cycle after DONE.
            if (pulses == 1 && !switched) begin
                switched = 1'b1;
                bus.req_rd = 5'd6; bus.operand_a = 32'd5; bus.operand_b = 32'd6;
            end
            if (pulses >= 2) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        check("b2b pulse_count", 32'(pulses), 32'd2);
        while (sb.size() > 0) void'(sb.pop_front());
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t v;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        reset_n = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rd = '0;
        bus.operand_a = '0; bus.operand_b = '0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset stall", 32'(bus.stall_out), 32'd0);
        check("reset valid", 32'(bus.result_valid), 32'd0);
        check("reset data", bus.result_data, 32'd0);
        check("reset rd", 32'(bus.result_rd), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;

        vecs.push_back('{3'd0, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, "MUL 7*-3"});
        vecs.push_back('{3'd1, 32'h80000000,  32'h80000000, 5'd1,  32'h40000000, "MULH min*min"});
        vecs.push_back('{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, "MULHU max"});
        vecs.push_back('{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, "MULHSU -1*max"});
        vecs.push_back('{3'd4, 32'hFFFFFFF9,  32'd2,        5'd7,  32'hFFFFFFFD, "DIV -7/2"});
        vecs.push_back('{3'd6, 32'hFFFFFFF9,  32'd2,        5'd8,  32'hFFFFFFFF, "REM -7/2"});
        vecs.push_back('{3'd5, 32'd100,       32'd7,        5'd10, 32'd14,       "DIVU 100/7"});
        vecs.push_back('{3'd7, 32'd100,       32'd7,        5'd11, 32'd2,        "REMU 100/7"});
        vecs.push_back('{3'd4, 32'd5,         32'd0,        5'd12, 32'hFFFFFFFF, "DIV 5/0"});
        vecs.push_back('{3'd6, 32'hFFFFFFFB,  32'd0,        5'd13, 32'hFFFFFFFB, "REM -5/0"});
        vecs.push_back('{3'd4, 32'h80000000,  32'hFFFFFFFF, 5'd14, 32'h80000000, "DIV ovf"});
        vecs.push_back('{3'd6, 32'h80000000,  32'hFFFFFFFF, 5'd15, 32'd0,        "REM ovf"});
        vecs.push_back('{3'd0, 32'd0,         32'd12345,    5'd16, 32'd0,        "MUL 0*x"});
        foreach (vecs[i]) begin
            v = vecs[i];
            run_op(v.tag, v.op, v.a, v.b, v.rd, v.exp);
        end

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) rb = 32'd1 + 32'($urandom_range(0, 15));
            run_op("random", rop, ra, rb, 5'(i + 17), ref_res(rop, ra, rb));
        end

        abort_op("flush", 1'b0);
        abort_op("reset", 1'b1);
        back_to_back();

`ifdef MULDIV_EARLY_OUT_EN
        run_op("early DIVU 9/0", 3'd5, 32'd9, 32'd0, 5'd20, 32'hFFFFFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
